motor_ramp_ctrl: RTL and testbench

Sequencing controller for one rover drive channel. It accepts speed/direction commands over a valid/ready handshake and slews the duty-cycle command toward the target at a fixed rate. Direction reversals are sequenced as ramp-to-zero, dead time with the driver disabled, direction flip, then ramp-up. Outputs `duty`/`dir`/`drv_en` feed the PWM generator and H-bridge direction pins; one instance per motor.

---
 rtl/motor_ramp_ctrl.sv | 171 +++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp_ctrl.sv
// Drive-channel ramp sequencer: slews duty toward a commanded target and
// sequences direction reversals through ramp-to-zero and a dead interval.
module motor_ramp_ctrl #(
    parameter int DUTY_MAX    = 100,
    parameter int STEP        = 1,
    parameter int RAMP_DIV    = 1000,
    parameter int DEAD_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [6:0] cmd_duty,
    input  logic       estop,
    output logic [6:0] duty,
    output logic       dir,
    output logic       drv_en,
    output logic       busy
);

    localparam int PW = $clog2(RAMP_DIV);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [6:0]    DMAX     = 7'(DUTY_MAX);
    localparam logic [7:0]    STEP8    = 8'(STEP);
    localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_TOP = DW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RAMP,
        S_DEAD
    } state_e;

    state_e        state_q, state_d;
    logic [6:0]    duty_q, duty_d;
    logic          dir_q, dir_d;
    logic          drv_en_q, drv_en_d;
    logic          tgt_dir_q, tgt_dir_d;
    logic [6:0]    tgt_duty_q, tgt_duty_d;
    logic [6:0]    eff_q, eff_d;
    logic          rev_pend_q, rev_pend_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [DW-1:0] dead_q, dead_d;

    logic       accept;
    logic       tick;
    logic [6:0] clamp;
    logic [7:0] duty8, eff8, up8, dn8;
    logic [6:0] duty_up, duty_dn;

    assign cmd_ready = !estop && (state_q != S_DEAD);
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (state_q == S_RAMP) && (pre_q == PRE_LAST);
    assign clamp     = (cmd_duty > DMAX) ? DMAX : cmd_duty;

    // 8-bit intermediates keep the step from wrapping at either end.
    assign duty8   = {1'b0, duty_q};
    assign eff8    = {1'b0, eff_q};
    assign up8     = duty8 + STEP8;
    assign dn8     = duty8 - STEP8;
    assign duty_up = (up8 > eff8) ? eff_q : up8[6:0];
    assign duty_dn = (duty8 >= eff8 + STEP8) ? dn8[6:0] : eff_q;

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        tgt_dir_d  = tgt_dir_q;
        tgt_duty_d = tgt_duty_q;
        eff_d      = eff_q;
        rev_pend_d = rev_pend_q;
        pre_d      = pre_q;
        dead_d     = dead_q;
        if (estop) begin
            duty_d     = '0;
            state_d    = S_IDLE;
            rev_pend_d = 1'b0;
            pre_d      = '0;
            dead_d     = '0;
        end else if (accept) begin
            tgt_dir_d  = cmd_dir;
            tgt_duty_d = clamp;
            pre_d      = '0;
            if (cmd_dir != dir_q && duty_q != '0) begin
                rev_pend_d = 1'b1;
                eff_d      = '0;
                state_d    = S_RAMP;
            end else if (cmd_dir != dir_q) begin
                rev_pend_d = 1'b0;
                dead_d     = DEAD_TOP;
                state_d    = S_DEAD;
            end else begin
                rev_pend_d = 1'b0;
                eff_d      = clamp;
                state_d    = S_RAMP;
            end
        end else begin
            unique case (state_q)
                S_RAMP: begin
                    if (tick) begin
                        pre_d = '0;
                        if (duty_q < eff_q) begin
                            duty_d = duty_up;
                        end else if (duty_q > eff_q) begin
                            duty_d = duty_dn;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                        if (duty_q == eff_q) begin
                            if (rev_pend_q) begin
                                dead_d  = DEAD_TOP;
                                state_d = S_DEAD;
                            end else if (duty_q == '0) begin
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_HOLD;
                            end
                        end
                    end
                end
                S_DEAD: begin
                    if (dead_q == '0) begin
                        dir_d      = tgt_dir_q;
                        rev_pend_d = 1'b0;
                        eff_d      = tgt_duty_q;
                        pre_d      = '0;
                        state_d    = (tgt_duty_q != '0) ? S_RAMP : S_IDLE;
                    end else begin
                        dead_d = dead_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
        drv_en_d = (state_d != S_DEAD) && (duty_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            duty_q     <= '0;
            dir_q      <= 1'b0;
            drv_en_q   <= 1'b0;
            tgt_dir_q  <= 1'b0;
            tgt_duty_q <= '0;
            eff_q      <= '0;
            rev_pend_q <= 1'b0;
            pre_q      <= '0;
            dead_q     <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            drv_en_q   <= drv_en_d;
            tgt_dir_q  <= tgt_dir_d;
            tgt_duty_q <= tgt_duty_d;
            eff_q      <= eff_d;
            rev_pend_q <= rev_pend_d;
            pre_q      <= pre_d;
            dead_q     <= dead_d;
        end
    end

    assign duty   = duty_q;
    assign dir    = dir_q;
    assign drv_en = drv_en_q;
    assign busy   = (state_q == S_RAMP) || (state_q == S_DEAD);

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: timeline model compared every cycle, plus
// hand-computed duty/dir checkpoints along the directed sequence.
module tb_motor_ramp_ctrl;

    localparam int RD = 4;
    localparam int ST = 10;
    localparam int DC = 8;
    localparam int DM = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_dir = 1'b0;
    logic [6:0] cmd_duty = '0;
    logic       estop = 1'b0;
    logic [6:0] duty;
    logic       dir;
    logic       drv_en;
    logic       busy;

    int n_chk = 0;
    int n_pass = 0;

    motor_ramp_ctrl #(
        .DUTY_MAX(DM),
        .STEP(ST),
        .RAMP_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_duty(cmd_duty),
        .estop(estop),
        .duty(duty),
        .dir(dir),
        .drv_en(drv_en),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Timeline model: settled / moving toward a goal / paused for reversal.
    localparam int SET = 0;
    localparam int MOV = 1;
    localparam int PAU = 2;

    int m_duty, m_dir, m_mode, m_timer, m_dead, m_goal, m_wdir, m_want, m_en;
    int nd, ndir, nmode, nt, ndead, ng, nwd, nw;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_duty <= 0; m_dir <= 0; m_mode <= SET; m_timer <= 0;
            m_dead <= 0; m_goal <= 0; m_wdir <= 0; m_want <= 0; m_en <= 0;
        end else begin
            nd = m_duty; ndir = m_dir; nmode = m_mode; nt = m_timer;
            ndead = m_dead; ng = m_goal; nwd = m_wdir; nw = m_want;
            if (estop) begin
                nd = 0;
                nmode = SET;
            end else if (cmd_valid && m_mode != PAU) begin
                nw = (int'(cmd_duty) > DM) ? DM : int'(cmd_duty);
                nwd = int'(cmd_dir);
                if (nwd != m_dir && m_duty != 0) begin
                    nmode = MOV; ng = 0; nt = RD;
                end else if (nwd != m_dir) begin
                    nmode = PAU; ndead = DC;
                end else begin
                    nmode = MOV; ng = nw; nt = RD;
                end
            end else if (m_mode == MOV) begin
                if (m_timer == 1) begin
                    nt = RD;
                    if (m_duty < m_goal)
                        nd = (m_duty + ST > m_goal) ? m_goal : m_duty + ST;
                    else if (m_duty > m_goal)
                        nd = (m_duty - ST < m_goal) ? m_goal : m_duty - ST;
                end else if (m_duty == m_goal) begin
                    if (m_wdir != m_dir) begin
                        nmode = PAU; ndead = DC;
                    end else begin
                        nmode = SET;
                    end
                end else begin
                    nt = m_timer - 1;
                end
            end else if (m_mode == PAU) begin
                if (m_dead == 1) begin
                    ndir = m_wdir;
                    if (m_want != 0) begin
                        nmode = MOV; ng = m_want; nt = RD;
                    end else begin
                        nmode = SET;
                    end
                end else begin
                    ndead = m_dead - 1;
                end
            end
            m_duty <= nd; m_dir <= ndir; m_mode <= nmode; m_timer <= nt;
            m_dead <= ndead; m_goal <= ng; m_wdir <= nwd; m_want <= nw;
            m_en <= (nmode != PAU && nd != 0) ? 1 : 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            chk("m_duty", int'(duty), m_duty);
            chk("m_dir", int'(dir), m_dir);
            chk("m_drv_en", int'(drv_en), m_en);
            chk("m_busy", int'(busy), (m_mode != SET) ? 1 : 0);
            chk("m_ready", int'(cmd_ready), (!estop && m_mode != PAU) ? 1 : 0);
        end
    end

    task automatic accept(input logic d, input logic [6:0] v);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_duty  = v;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wt(2);
        reset = 1'b1;
        chk("rst_duty", int'(duty), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_en", int'(drv_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        wt(1);

        accept(1'b0, 7'd35);
        wt(4);  chk("up_10", int'(duty), 10);
        wt(4);  chk("up_20", int'(duty), 20);
        wt(4);  chk("up_30", int'(duty), 30);
        wt(4);  chk("up_35", int'(duty), 35);
        chk("up_busy16", int'(busy), 1);
        wt(1);  chk("up_busy17", int'(busy), 0);
        chk("up_en", int'(drv_en), 1);

        accept(1'b0, 7'd40);
        wt(4);  chk("to_40", int'(duty), 40);
        wt(1);
        accept(1'b1, 7'd20);
        wt(16); chk("rv_zero", int'(duty), 0);
        chk("rv_dir_hold", int'(dir), 0);
        wt(1);  chk("dead_en", int'(drv_en), 0);
        chk("dead_ready", int'(cmd_ready), 0);
        chk("dead_busy", int'(busy), 1);
        wt(7);  chk("dead_last_ready", int'(cmd_ready), 0);
        chk("dead_last_dir", int'(dir), 0);
        wt(1);  chk("flip_dir", int'(dir), 1);
        chk("flip_ready", int'(cmd_ready), 1);
        wt(4);  chk("rv_10", int'(duty), 10);
        wt(4);  chk("rv_20", int'(duty), 20);
        wt(1);  chk("rv_settle", int'(busy), 0);

        accept(1'b1, 7'd0);
        wt(9);  chk("down_idle", int'(busy), 0);
        accept(1'b1, 7'd120);
        wt(36); chk("clamp_90", int'(duty), 90);
        wt(4);  chk("clamp_100", int'(duty), 100);
        wt(1);  chk("clamp_settle", int'(busy), 0);
        wt(8);  chk("clamp_stays", int'(duty), 100);

        accept(1'b1, 7'd0);
        wt(41);
        accept(1'b1, 7'd80);
        wt(12); chk("es_pre", int'(duty), 30);
        estop = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_duty = 7'd50;
        wt(1);  chk("es_duty", int'(duty), 0);
        chk("es_en", int'(drv_en), 0);
        chk("es_busy", int'(busy), 0);
        chk("es_ready", int'(cmd_ready), 0);
        estop = 1'b0; cmd_valid = 1'b0;
        wt(2);  chk("es_noacc", int'(busy), 0);
        chk("es_duty2", int'(duty), 0);

        accept(1'b1, 7'd90);
        wt(20); chk("rt_50", int'(duty), 50);
        accept(1'b1, 7'd20);
        wt(4);  chk("rt_40", int'(duty), 40);
        wt(4);  chk("rt_30", int'(duty), 30);
        wt(4);  chk("rt_20", int'(duty), 20);
        wt(1);  chk("rt_hold", int'(busy), 0);

        accept(1'b1, 7'd20);
        chk("eq_busy", int'(busy), 1);
        wt(1);  chk("eq_settle", int'(busy), 0);
        chk("eq_duty", int'(duty), 20);

        accept(1'b0, 7'd30);
        wt(9);  chk("ar_dead", int'(busy), 1);
        chk("ar_dir1", int'(dir), 1);
        wt(3);
        #2 reset = 1'b0;
        #1;
        chk("ar_duty", int'(duty), 0);
        chk("ar_dir", int'(dir), 0);
        chk("ar_en", int'(drv_en), 0);
        chk("ar_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        wt(2);
        chk("ar_ready", int'(cmd_ready), 1);
        chk("ar_dir_rel", int'(dir), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
